// File: rtl/ppu_pkg.sv
// Shared PPU types and width helpers for the FIR datapath.
// fir_t is laid out {sign, te, frac} at the default FIR widths.
package ppu_pkg;

    localparam int DEF_FIR_TE_SIZE   = 7;
    localparam int DEF_FIR_FRAC_SIZE = 14;

    typedef struct packed {
        logic                         sign;
        logic [DEF_FIR_TE_SIZE-1:0]   te;
        logic [DEF_FIR_FRAC_SIZE-1:0] frac;
    } fir_t;

    function automatic int fir_width(input int te_size, input int frac_size);
        return 1 + te_size + frac_size;
    endfunction

    function automatic int lzc_width(input int fx_b);
        return $clog2(fx_b) + 1;
    endfunction

endpackage

// File: rtl/fixed_to_fir.sv
// Combinational unsigned fixed-point Fx<FX_M,FX_B> to FIR converter.
// The output is te = FX_M - lzc - 1, frac = {1, bits below the leading one}, and sign = the input MSB.
module fixed_to_fir
    import ppu_pkg::*;
#(
    parameter int FIR_TE_SIZE   = 7,
    parameter int FIR_FRAC_SIZE = 14,
    parameter int FX_M          = 32,
    parameter int FX_B          = 64,
    localparam int FIR_W        = fir_width(FIR_TE_SIZE, FIR_FRAC_SIZE),
    localparam int LZC_W        = lzc_width(FX_B)
) (
    input  logic [FX_B-1:0]  fixed,
    output logic [FIR_W-1:0] fir
);

    logic [LZC_W-1:0]         lzc;
    logic [FIR_TE_SIZE-1:0]   te;
    logic [FIR_FRAC_SIZE-2:0] frac_bits;

    // Ascending scan: the last hit is the leading one. All-zero input leaves lzc = FX_B.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        lzc = LZC_W'(FX_B);
        for (int i = 0; i < FX_B; i++) begin
            if (fixed[i]) lzc = LZC_W'(FX_B - 1 - i);
        end
    end

    assign te        = FIR_TE_SIZE'(FX_M - 1 - int'(lzc));
    assign frac_bits = (FIR_FRAC_SIZE-1)'((fixed << (lzc + 1)) >> (FX_B - FIR_FRAC_SIZE + 1));
    assign fir       = {fixed[FX_B-1], te, 1'b1, frac_bits};

endmodule

// File: rtl/fixed_to_fir_arbiter.sv
// Round-robin arbiter that shares one fixed_to_fir converter among NUM_REQ requesters and registers the result.
// The build option FX2FIR_ZERO_DETECT_EN makes an all-zero input load fir = 0 and out_zero_o = 1.
module fixed_to_fir_arbiter
    import ppu_pkg::*;
#(
    parameter int N             = 16,
    parameter int FIR_TE_SIZE   = 7,
    parameter int FIR_FRAC_SIZE = 14,
    parameter int FX_M          = 32,
    parameter int FX_B          = 64,
    parameter int NUM_REQ       = 4,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int FIR_W        = fir_width(FIR_TE_SIZE, FIR_FRAC_SIZE)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*FX_B-1:0] req_fixed_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [FIR_W-1:0]        out_fir_o,
    output logic [ID_W-1:0]         out_id_o,
    output logic                    out_zero_o
);

    if (FIR_TE_SIZE < lzc_width(FX_B) || FIR_FRAC_SIZE > N - 2 || NUM_REQ < 1) begin : g_param_check
        $error("fixed_to_fir_arbiter: inconsistent FIR/posit/requester parameters");
    end

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  next_ptr;
    logic             found;
    logic             can_accept;
    logic             transfer;
    logic [FX_B-1:0]  sel_fixed;
    logic [FIR_W-1:0] conv_fir;
    logic [FIR_W-1:0] load_fir;

    function automatic int wrap_idx(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'(wrap_idx(int'(rr_ptr) + k));
            if (req_valid_i[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
    end

    assign can_accept  = !out_valid_o || out_ready_i;
    assign transfer    = found && can_accept && rst_i;
    assign req_ready_o = transfer ? (NUM_REQ'(1) << grant_id) : '0;
    assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign sel_fixed   = req_fixed_i[grant_id*FX_B +: FX_B];

    fixed_to_fir #(
        .FIR_TE_SIZE  (FIR_TE_SIZE),
        .FIR_FRAC_SIZE(FIR_FRAC_SIZE),
        .FX_M         (FX_M),
        .FX_B         (FX_B)
    ) u_fixed_to_fir (
        .fixed(sel_fixed),
        .fir  (conv_fir)
    );

`ifdef FX2FIR_ZERO_DETECT_EN
    logic load_zero;
    logic zero_q;

    assign load_zero = ~|sel_fixed;
    assign load_fir  = load_zero ? '0 : conv_fir;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)        zero_q <= 1'b0;
        else if (transfer) zero_q <= load_zero;
    end

    assign out_zero_o = zero_q;
`else
    assign load_fir   = conv_fir;
    assign out_zero_o = 1'b0;
`endif

    // A drain without a refill only clears the valid flag. The data fields keep their values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_i) begin
            out_valid_o <= 1'b0;
            out_fir_o   <= '0;
            out_id_o    <= '0;
            rr_ptr      <= '0;
        end else if (transfer) begin
            out_valid_o <= 1'b1;
            out_fir_o   <= load_fir;
            out_id_o    <= grant_id;
            rr_ptr      <= next_ptr;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fixed_to_fir_arbiter.sv
// Directed self-checking bench for fixed_to_fir_arbiter at default parameters.
// Build with FX2FIR_ZERO_DETECT_EN defined to exercise the zero-detect variant.
module tb_fixed_to_fir_arbiter;
    import ppu_pkg::*;

    localparam int FX_B    = 64;
    localparam int NUM_REQ = 4;

    localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;
    localparam logic [63:0] TWO   = 64'h0000_0002_0000_0000;
    localparam logic [63:0] FOUR  = 64'h0000_0004_0000_0000;
    localparam logic [63:0] EIGHT = 64'h0000_0008_0000_0000;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ*FX_B-1:0] req_fixed_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [21:0]             out_fir_o;
    logic [1:0]              out_id_o;
    logic                    out_zero_o;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    fir_t f;

    fixed_to_fir_arbiter dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_valid_i(req_valid_i),
        .req_fixed_i(req_fixed_i),
        .req_ready_o(req_ready_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_fir_o  (out_fir_o),
        .out_id_o   (out_id_o),
        .out_zero_o (out_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_fixed(input int k, input logic [63:0] v);
        req_fixed_i[k*FX_B +: FX_B] = v;
    endtask

    task automatic test_reset;
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        req_valid_i = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) set_fixed(k, ONE);
        tick;
        tick;
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid_o); else pass_cnt++;
        total_cnt++; if (out_fir_o !== 22'h0) $display("FAIL reset_fir got=%h want=0", out_fir_o); else pass_cnt++;
        total_cnt++; if (out_id_o !== 2'd0) $display("FAIL reset_id got=%0d want=0", out_id_o); else pass_cnt++;
        total_cnt++; if (out_zero_o !== 1'b0) $display("FAIL reset_zero got=%b want=0", out_zero_o); else pass_cnt++;
        total_cnt++; if (req_ready_o !== 4'b0000) $display("FAIL reset_ready got=%b want=0000", req_ready_o); else pass_cnt++;
        req_valid_i = '0;
        rst_i       = 1'b1;
        tick;
    endtask

    // Pointer starts at 0: grants cycle 0,1,2,3 with te equal to the id.
    task automatic test_round_robin;
        logic [3:0] exp_rdy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        set_fixed(0, ONE);
        set_fixed(1, TWO);
        set_fixed(2, FOUR);
        set_fixed(3, EIGHT);
        req_valid_i = 4'b1111;
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total_cnt++; if (req_ready_o !== exp_rdy[i%4]) $display("FAIL rr_ready[%0d] got=%b want=%b", i, req_ready_o, exp_rdy[i%4]); else pass_cnt++;
            tick;
            f = out_fir_o;
            total_cnt++; if (out_valid_o !== 1'b1) $display("FAIL rr_valid[%0d] got=%b want=1", i, out_valid_o); else pass_cnt++;
            total_cnt++; if (out_id_o !== 2'(i%4)) $display("FAIL rr_id[%0d] got=%0d want=%0d", i, out_id_o, i%4); else pass_cnt++;
            total_cnt++; if (f.te !== 7'(i%4) || f.frac !== 14'h2000) $display("FAIL rr_fir[%0d] got=te %h frac %h want=te %h frac 2000", i, f.te, f.frac, i%4); else pass_cnt++;
        end
        req_valid_i = '0;
        tick;
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rr_drain got=%b want=0", out_valid_o); else pass_cnt++;
    endtask

    task automatic test_single;
        set_fixed(2, ONE);
        req_valid_i = 4'b0100;
        #1;
        total_cnt++; if (req_ready_o !== 4'b0100) $display("FAIL single_ready got=%b want=0100", req_ready_o); else pass_cnt++;
        tick;
        f = out_fir_o;
        total_cnt++; if (out_valid_o !== 1'b1) $display("FAIL single_valid got=%b want=1", out_valid_o); else pass_cnt++;
        total_cnt++; if (out_id_o !== 2'd2) $display("FAIL single_id got=%0d want=2", out_id_o); else pass_cnt++;
        total_cnt++; if (f !== fir_t'({1'b0, 7'h00, 14'h2000})) $display("FAIL single_fir got=%h want=%h", f, {1'b0, 7'h00, 14'h2000}); else pass_cnt++;
        req_valid_i = '0;
        tick;
    endtask

    task automatic test_stall;
        set_fixed(0, TWO);
        req_valid_i = 4'b0001;
        tick;
        set_fixed(1, FOUR);
        req_valid_i = 4'b0010;
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (req_ready_o !== 4'b0000) $display("FAIL stall_ready[%0d] got=%b want=0000", i, req_ready_o); else pass_cnt++;
            tick;
            f = out_fir_o;
            total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 2'd0 || f.te !== 7'h01) $display("FAIL stall_hold[%0d] got=v%b id%0d te%h want=v1 id0 te01", i, out_valid_o, out_id_o, f.te); else pass_cnt++;
        end
        out_ready_i = 1'b1;
        #1;
        total_cnt++; if (req_ready_o !== 4'b0010) $display("FAIL stall_release_ready got=%b want=0010", req_ready_o); else pass_cnt++;
        tick;
        f = out_fir_o;
        total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 2'd1 || f.te !== 7'h02) $display("FAIL stall_refill got=v%b id%0d te%h want=v1 id1 te02", out_valid_o, out_id_o, f.te); else pass_cnt++;
        req_valid_i = '0;
        tick;
    endtask

    // The pointer sits at 2: requester 3 wins over 1, then 1 is granted, and the pointer returns to 2.
    task automatic test_wrap;
        set_fixed(3, EIGHT);
        set_fixed(1, 64'h0000_0001_8000_0000);
        req_valid_i = 4'b1010;
        #1;
        total_cnt++; if (req_ready_o !== 4'b1000) $display("FAIL wrap_ready3 got=%b want=1000", req_ready_o); else pass_cnt++;
        tick;
        f = out_fir_o;
        total_cnt++; if (out_id_o !== 2'd3 || f.te !== 7'h03) $display("FAIL wrap_id3 got=id%0d te%h want=id3 te03", out_id_o, f.te); else pass_cnt++;
        req_valid_i = 4'b0010;
        #1;
        total_cnt++; if (req_ready_o !== 4'b0010) $display("FAIL wrap_ready1 got=%b want=0010", req_ready_o); else pass_cnt++;
        tick;
        f = out_fir_o;
        total_cnt++; if (out_id_o !== 2'd1 || f.te !== 7'h00 || f.frac !== 14'h3000) $display("FAIL wrap_id1 got=id%0d te%h frac%h want=id1 te00 frac3000", out_id_o, f.te, f.frac); else pass_cnt++;
        set_fixed(2, FOUR);
        req_valid_i = 4'b0110;
        #1;
        total_cnt++; if (req_ready_o !== 4'b0100) $display("FAIL wrap_ptr_end got=%b want=0100", req_ready_o); else pass_cnt++;
        tick;
        req_valid_i = '0;
        tick;
    endtask

    task automatic test_boundary;
        req_valid_i = 4'b0001;
        set_fixed(0, 64'h8000_0000_0000_0000);
        tick;
        f = out_fir_o;
        total_cnt++; if (f !== fir_t'({1'b1, 7'h1F, 14'h2000})) $display("FAIL bnd_msb got=%h want=%h", f, {1'b1, 7'h1F, 14'h2000}); else pass_cnt++;
        set_fixed(0, 64'h1);
        tick;
        f = out_fir_o;
        total_cnt++; if (f !== fir_t'({1'b0, 7'h60, 14'h2000})) $display("FAIL bnd_lsb got=%h want=%h", f, {1'b0, 7'h60, 14'h2000}); else pass_cnt++;
        set_fixed(0, 64'h0000_0000_C000_0000);
        tick;
        f = out_fir_o;
        total_cnt++; if (f !== fir_t'({1'b0, 7'h7F, 14'h3000})) $display("FAIL bnd_frac got=%h want=%h", f, {1'b0, 7'h7F, 14'h3000}); else pass_cnt++;
        set_fixed(0, 64'h0);
        tick;
`ifdef FX2FIR_ZERO_DETECT_EN
        total_cnt++; if (out_zero_o !== 1'b1) $display("FAIL zero_flag got=%b want=1", out_zero_o); else pass_cnt++;
        total_cnt++; if (out_fir_o !== 22'h0) $display("FAIL zero_fir got=%h want=0", out_fir_o); else pass_cnt++;
`else
        total_cnt++; if (out_zero_o !== 1'b0) $display("FAIL zero_flag got=%b want=0", out_zero_o); else pass_cnt++;
`endif
        set_fixed(0, ONE);
        tick;
        f = out_fir_o;
        total_cnt++; if (out_zero_o !== 1'b0 || f.te !== 7'h00) $display("FAIL zero_clear got=z%b te%h want=z0 te00", out_zero_o, f.te); else pass_cnt++;
        req_valid_i = '0;
        tick;
    endtask

    task automatic test_reset_mid;
        set_fixed(0, ONE);
        req_valid_i = 4'b0001;
        tick;
        req_valid_i = 4'b0101;
        #2;
        rst_i = 1'b0;
        #1;
        total_cnt++; if (out_valid_o !== 1'b0 || out_fir_o !== 22'h0 || out_id_o !== 2'd0) $display("FAIL mid_reset_out got=v%b fir%h id%0d want=v0 fir0 id0", out_valid_o, out_fir_o, out_id_o); else pass_cnt++;
        total_cnt++; if (req_ready_o !== 4'b0000) $display("FAIL mid_reset_ready got=%b want=0000", req_ready_o); else pass_cnt++;
        tick;
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL mid_reset_hold got=%b want=0", out_valid_o); else pass_cnt++;
        rst_i       = 1'b1;
        req_valid_i = 4'b1111;
        #1;
        total_cnt++; if (req_ready_o !== 4'b0001) $display("FAIL post_reset_ready got=%b want=0001", req_ready_o); else pass_cnt++;
        tick;
        total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 2'd0) $display("FAIL post_reset_grant got=v%b id%0d want=v1 id0", out_valid_o, out_id_o); else pass_cnt++;
        req_valid_i = '0;
        tick;
    endtask

    initial begin
        req_fixed_i = '0;
        test_reset;
        test_round_robin;
        test_single;
        test_stall;
        test_wrap;
        test_boundary;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
